// File: rtl/fpu_defs_div_sqrt.sv
// Shared definitions for the div/sqrt unit: widths, controller state encoding
// and the precision / iteration-count helpers also used by the parent datapath.
package fpu_defs_div_sqrt;

   localparam int unsigned C_MANT  = 52;
   localparam int unsigned C_PC    = 6;
   localparam int unsigned C_CNT_W = $clog2(C_MANT + 4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } ctrl_state_t;

   // Zero or oversize requests mean full precision; tiny requests are raised to the floor.
   function automatic logic [C_CNT_W-1:0] eff_prec(input logic [C_PC-1:0] ctl,
                                                   input int unsigned  min_prec);
      logic [C_CNT_W-1:0] p;
      if ((ctl == C_PC'(0)) || (32'(ctl) > (C_MANT + 1))) begin
         p = C_CNT_W'(C_MANT + 1);
      end else if (32'(ctl) < min_prec) begin
         p = C_CNT_W'(min_prec);
      end else begin
         p = C_CNT_W'(ctl);
      end
      return p;
   endfunction

   // Guard and round bits ride along with the mantissa bits, rounded up to whole cycles.
   function automatic logic [C_CNT_W-1:0] iter_cycles(input logic [C_CNT_W-1:0] p,
                                                      input int unsigned     unroll);
      logic [C_CNT_W:0] num;
      num = {1'b0, p} + (C_CNT_W + 1)'(unroll + 1);
      return C_CNT_W'(num / (C_CNT_W + 1)'(unroll));
   endfunction

endpackage

// File: rtl/div_sqrt_prec_decode.sv
// Combinational clamp of the requested precision to the effective precision P
// and the resulting iteration-cycle count N.
module div_sqrt_prec_decode
   import fpu_defs_div_sqrt::*;
#(
   parameter int unsigned UNROLL   = 1,
   parameter int unsigned MIN_PREC = 6
) (
   input  logic [C_PC-1:0]    Precision_ctl_SI,
   output logic [C_CNT_W-1:0] Iter_num_DO
);

   logic [C_CNT_W-1:0] prec_d;

   // Effective precision feeds straight into the cycle count.
   always_comb begin
      prec_d      = eff_prec(Precision_ctl_SI, MIN_PREC);
      Iter_num_DO = iter_cycles(prec_d, UNROLL);
   end

endmodule

// File: rtl/div_sqrt_iter_ctrl.sv
// Sequencing controller for the radix-2 div/sqrt iteration datapath: start
// acceptance, load strobe, mode enables, iteration counter and done pulse.
module div_sqrt_iter_ctrl
   import fpu_defs_div_sqrt::*;
#(
   parameter int unsigned UNROLL   = 1,
   parameter int unsigned MIN_PREC = 6
) (
   input  logic               Clk_CI,
   input  logic               Rst_RBI,
   input  logic               Div_start_SI,
   input  logic               Sqrt_start_SI,
   input  logic               Kill_SI,
   input  logic [C_PC-1:0]    Precision_ctl_SI,
   output logic               Ready_SO,
   output logic               Load_SO,
   output logic               Div_enable_SO,
   output logic               Sqrt_enable_SO,
   output logic [1:0]         Sqrt_D_seed_DO,
   output logic               First_iter_SO,
   output logic [C_CNT_W-1:0] Iter_cnt_DO,
   output logic               Done_SO
);

   ctrl_state_t        state_q;
   logic [C_CNT_W-1:0] iter_num_d;
   logic [C_CNT_W-1:0] iter_num_q;
   logic [C_CNT_W-1:0] cnt_q;
   logic               ready_q;
   logic               load_q;
   logic               div_en_q;
   logic               sqrt_en_q;
   logic               first_q;
   logic               done_q;

   div_sqrt_prec_decode #(
      .UNROLL   (UNROLL),
      .MIN_PREC (MIN_PREC)
   ) u_prec_decode (
      .Precision_ctl_SI (Precision_ctl_SI),
      .Iter_num_DO      (iter_num_d)
   );

   // Controller FSM; every output is computed one cycle ahead and registered.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         state_q    <= IDLE;
         iter_num_q <= '0;
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         load_q     <= 1'b0;
         div_en_q   <= 1'b0;
         sqrt_en_q  <= 1'b0;
         first_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         load_q  <= 1'b0;
         first_q <= 1'b0;
         done_q  <= 1'b0;
         if (Kill_SI && (state_q != IDLE)) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            div_en_q  <= 1'b0;
            sqrt_en_q <= 1'b0;
            cnt_q     <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  // Kill in IDLE suppresses a simultaneous start; division wins a tie.
                  if (!Kill_SI && (Div_start_SI || Sqrt_start_SI)) begin
                     state_q    <= LOAD;
                     iter_num_q <= iter_num_d;
                     ready_q    <= 1'b0;
                     load_q     <= 1'b1;
                     div_en_q   <= Div_start_SI;
                     sqrt_en_q  <= ~Div_start_SI;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               LOAD: begin
                  state_q <= ITER;
                  first_q <= 1'b1;
                  cnt_q   <= '0;
               end
               ITER: begin
                  if (cnt_q == (iter_num_q - C_CNT_W'(1))) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     div_en_q  <= 1'b0;
                     sqrt_en_q <= 1'b0;
                     cnt_q     <= '0;
                  end else begin
                     cnt_q <= cnt_q + C_CNT_W'(1);
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
               default: begin
                  state_q   <= IDLE;
                  ready_q   <= 1'b1;
                  div_en_q  <= 1'b0;
                  sqrt_en_q <= 1'b0;
                  cnt_q     <= '0;
               end
            endcase
         end
      end
   end

   // The seed digit is zero for both ops; the parent switches feedback on First_iter_SO.
   assign Sqrt_D_seed_DO = 2'b00;
   assign Ready_SO       = ready_q;
   assign Load_SO        = load_q;
   assign Div_enable_SO  = div_en_q;
   assign Sqrt_enable_SO = sqrt_en_q;
   assign First_iter_SO  = first_q;
   assign Iter_cnt_DO    = cnt_q;
   assign Done_SO        = done_q;

endmodule

// File: tb/tb_div_sqrt_iter_ctrl.sv
// Scoreboard bench for div_sqrt_iter_ctrl: timeline reference model for the
// per-cycle outputs plus a queue of expected done cycles checked by a monitor.
module tb_div_sqrt_iter_ctrl;

   localparam int unsigned U    = 2;
   localparam int          MINP = 6;
   localparam int          NDIR = 10;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       div_s  = 1'b0;
   logic       sqrt_s = 1'b0;
   logic       kill   = 1'b0;
   logic [5:0] prec   = 6'd0;

   logic       ready_o, load_o, den_o, sen_o, first_o, done_o;
   logic [1:0] seed_o;
   logic [5:0] cnt_o;
   logic [13:0] dut_vec;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   bit          busy = 1'b0;
   bit          op_div = 1'b0;
   int          t = 0;
   int          n = 0;
   int unsigned exp_q[$];

   int d_op   [NDIR] = '{0, 1, 0, 0, 2, 0, 1, 0, 1, 0};
   int d_prec [NDIR] = '{0, 23, 3, 60, 10, 20, 40, 0, 9, 54};
   int d_kill [NDIR] = '{-2, -2, -2, -2, -2, 12, -2, -1, 0, -2};
   int d_rst  [NDIR] = '{-2, -2, -2, -2, -2, -2, 8, -2, -2, -2};

   div_sqrt_iter_ctrl #(
      .UNROLL   (U),
      .MIN_PREC (MINP)
   ) dut (
      .Clk_CI           (clk),
      .Rst_RBI          (rst_n),
      .Div_start_SI     (div_s),
      .Sqrt_start_SI    (sqrt_s),
      .Kill_SI          (kill),
      .Precision_ctl_SI (prec),
      .Ready_SO         (ready_o),
      .Load_SO          (load_o),
      .Div_enable_SO    (den_o),
      .Sqrt_enable_SO   (sen_o),
      .Sqrt_D_seed_DO   (seed_o),
      .First_iter_SO    (first_o),
      .Iter_cnt_DO      (cnt_o),
      .Done_SO          (done_o)
   );

   assign dut_vec = {ready_o, load_o, den_o, sen_o, first_o, done_o, seed_o, cnt_o};

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int model_n(input int pr);
      int p;
      if (pr == 0 || pr > 53) p = 53;
      else if (pr < MINP)     p = MINP;
      else                    p = pr;
      return (p + 2 + int'(U) - 1) / int'(U);
   endfunction

   // Outputs implied by the position t on the operation timeline (t=1 is the load cycle).
   function automatic logic [13:0] exp_vec();
      logic r, l, de, se, f, d;
      int   c;
      r = 1'b1; l = 1'b0; de = 1'b0; se = 1'b0; f = 1'b0; d = 1'b0; c = 0;
      if (busy) begin
         r = 1'b0;
         if (t == 1) begin
            l = 1'b1; de = op_div; se = !op_div;
         end else if (t <= n + 1) begin
            de = op_div; se = !op_div; c = t - 2; f = (t == 2);
         end else begin
            d = 1'b1;
         end
      end
      return {r, l, de, se, f, d, 2'b00, 6'(c)};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 32'd1, 32'd0);
            end else begin
               check("done_cycle", cyc, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int   di, gap, rnd, drain, akill, arst, pr;
      logic r, k, dv, sq;
      di = 0; gap = 0; rnd = 0; drain = 0; akill = -2; arst = -2;
      for (int it = 0; it < 8000; it++) begin
         @(negedge clk);
         check("outputs", {18'd0, dut_vec}, {18'd0, exp_vec()});
         r = 1'b1; k = 1'b0; dv = 1'b0; sq = 1'b0;
         pr = int'($urandom_range(0, 63));
         if (it < 2) begin
            r = 1'b0;
         end else if (di < NDIR) begin
            if (!busy) begin
               if (gap > 0) begin
                  gap--;
               end else begin
                  dv    = (d_op[di] != 1);
                  sq    = (d_op[di] != 0);
                  pr    = d_prec[di];
                  k     = (d_kill[di] == 0);
                  akill = d_kill[di];
                  arst  = d_rst[di];
                  di++;
                  gap   = 2;
               end
            end else begin
               if (t == 4) dv = 1'b1;
               if ((akill == -1) ? (t == n + 2) : (t == akill)) k = 1'b1;
               if (t == arst) r = 1'b0;
            end
         end else if (rnd < 2500) begin
            rnd++;
            if (!busy) begin
               if ($urandom_range(0, 1) == 1) begin
                  dv = ($urandom_range(0, 1) == 1);
                  sq = ($urandom_range(0, 1) == 1);
               end
               k = ($urandom_range(0, 15) == 0);
            end else begin
               dv = ($urandom_range(0, 7) == 0);
               sq = ($urandom_range(0, 7) == 0);
               k  = ($urandom_range(0, 59) == 0);
            end
            r = !($urandom_range(0, 249) == 0);
            case ($urandom_range(0, 3))
               0:       pr = 0;
               1:       pr = int'($urandom_range(0, 8));
               default: pr = int'($urandom_range(0, 63));
            endcase
         end else begin
            drain++;
            if (drain > 40) break;
         end
         rst_n  = r;
         kill   = k;
         div_s  = dv;
         sqrt_s = sq;
         prec   = 6'(pr);
         #2;
         check("hold_until_edge", {18'd0, dut_vec}, {18'd0, exp_vec()});
         if (!r) begin
            if (busy && t != n + 2) void'(exp_q.pop_back());
            busy = 1'b0;
         end else if (!busy) begin
            if (!k && (dv || sq)) begin
               busy   = 1'b1;
               t      = 1;
               op_div = dv;
               n      = model_n(pr);
               exp_q.push_back(cyc + n + 2);
            end
         end else if (k) begin
            if (t != n + 2) void'(exp_q.pop_back());
            busy = 1'b0;
         end else begin
            t++;
            if (t > n + 2) busy = 1'b0;
         end
      end
      check("pending_done", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_sqrt_iter_ctrl.md
Name: div_sqrt_iter_ctrl

Overview:
Sequencing controller for the radix-2 div/sqrt iteration datapath, one instance per FPU div/sqrt unit.
- Accepts a div or sqrt start, latches operation and precision, and drives the datapath enables, operand-load strobe, sqrt digit seed and iteration counter.
- Signals completion with a one-cycle done pulse.
- Holds no mantissa data; partial-remainder and quotient registers sit in the parent and are clocked from this block's strobes.

Parameters:
UNROLL, 1, iteration cells chained per cycle (legal 1..4).
MIN_PREC, 6, smallest honoured mantissa precision in bits.
C_MANT and C_PC come from package fpu_defs_div_sqrt: C_MANT=52, C_PC=6.

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset; one clock; reset is synchronous and active-low
Div_start_SI  in  1  request division; sampled only when Ready_SO=1
Sqrt_start_SI  in  1  request square root; sampled only when Ready_SO=1
Kill_SI  in  1  abort current operation
Precision_ctl_SI  in  C_PC  requested mantissa bits; 0 selects full precision C_MANT+1
Ready_SO  out  1  idle, start accepted this cycle
Load_SO  out  1  parent loads operands into remainder/quotient registers
Div_enable_SO  out  1  datapath div mode
Sqrt_enable_SO  out  1  datapath sqrt mode
Sqrt_D_seed_DO  out  2  D digit injected into first sqrt cell on the first iteration
First_iter_SO  out  1  high in first ITER cycle
Iter_cnt_DO  out  CNT_W  current iteration index; CNT_W = $clog2(C_MANT+4)
Done_SO  out  1  one-cycle completion pulse

Behaviour:
- Reset (Rst_RBI=0 at a rising edge) state and outputs:
  - State goes to IDLE. Ready_SO=1. Iter_cnt_DO=0.
  - All other outputs are 0. Latched op and precision are cleared.
  - Reset mid-operation aborts with no Done_SO.
- States: IDLE, LOAD, ITER, DONE.
- IDLE:
  - Ready_SO=1.
  - Div_start_SI or Sqrt_start_SI high goes to LOAD next cycle.
  - Both starts high: division wins, sqrt request is dropped.
  - Op and effective precision are latched at the acceptance edge.
- Effective precision P:
  - Precision_ctl_SI=0 or >C_MANT+1 gives P=C_MANT+1.
  - Precision_ctl_SI<MIN_PREC gives P=MIN_PREC.
  - Otherwise P=Precision_ctl_SI.
- Iteration cycles N = ceil((P+2)/UNROLL). The two extra bits are guard and round. Computed at latch time and registered.
- LOAD (1 cycle):
  - Load_SO=1.
  - Div_enable_SO or Sqrt_enable_SO high per latched op, held high through LOAD and ITER.
  - Next state is ITER with Iter_cnt_DO=0.
- ITER (N cycles):
  - Iter_cnt_DO counts 0..N-1. First_iter_SO=1 only when the count is 0.
  - Sqrt_D_seed_DO=2'b00 when First_iter_SO=1 and op is sqrt; otherwise 2'b00 as well. The parent selects the feedback path using First_iter_SO.
  - On count N-1, next state is DONE.
- DONE (1 cycle):
  - Done_SO=1. Enables go low. Ready_SO=0.
  - Next state is IDLE. A start in DONE is ignored, not queued.
- Kill_SI:
  - In LOAD, ITER or DONE: next state is IDLE and enables drop next cycle.
  - Done_SO is not asserted. If Kill_SI arrives in the DONE cycle itself, that cycle's Done_SO still fires (already registered).
  - Kill_SI in IDLE has no effect. Kill_SI together with a start in IDLE: kill wins, start ignored.
- Latency:
  - Start accepted at edge k. Load_SO high during cycle k+1.
  - ITER occupies cycles k+2 .. k+N+1. Done_SO high in cycle k+N+2.
  - Ready_SO high again in cycle k+N+3.
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- Counter never wraps: it is bounded by N ≤ C_MANT+3 < 2^CNT_W.

Decomposition:
- Shared package fpu_defs_div_sqrt holds:
  - C_MANT and C_PC (existing).
  - New enum ctrl_state_t {IDLE, LOAD, ITER, DONE}.
  - Function for effective precision and N, so the parent can compute quotient width.
- One sub-module, div_sqrt_prec_decode: combinational clamp of Precision_ctl_SI to P and N. The FSM and counter stay in div_sqrt_iter_ctrl.

Test Plan:
- UNROLL=1, Div_start_SI=1 with Precision_ctl_SI=0 at cycle 0 → Load_SO at cycle 1; N=55; Iter_cnt_DO 0..54 in cycles 2..56; Done_SO=1 at cycle 57; Div_enable_SO=1 for cycles 1..56 only.
- UNROLL=2, Sqrt_start_SI=1 with Precision_ctl_SI=23 → N=13; First_iter_SO=1 only in cycle 2; Sqrt_D_seed_DO=2'b00 in cycle 2; Done_SO in cycle 15.
- Precision_ctl_SI=3 → clamped to 6, N=8 at UNROLL=1; Precision_ctl_SI=60 → P=53, N=55.
- Div and sqrt starts together → Div_enable_SO=1, Sqrt_enable_SO=0. A new start while busy (cycle 5) is ignored, and Ready_SO stays 0 until the end.
- Kill_SI=1 at Iter_cnt_DO=10 → IDLE next cycle, Ready_SO=1, no Done_SO pulse. A start in the following cycle is accepted normally.
- Rst_RBI=0 held for one edge during ITER → all outputs at reset values next cycle, no Done_SO. Rst_RBI=0 is ignored until a clock edge, confirming synchronous reset.
